ppfifo_stream_reader: RTL and testbench
=======================================

Name: ppfifo_stream_reader

Overview:
- Drains the read side of the SATA stack's user_dout ping-pong FIFO and re-emits the data as a valid/ready stream with a last-word marker per block.
- Sits directly downstream of sata_stack (user_dout_ready/activate/size/data/stb) and feeds user logic or a DMA sink.
- Absorbs downstream backpressure with a 2-entry output buffer; no word is lost or duplicated.

Parameters:
DATA_WIDTH, 32, width of FIFO data and stream data
SIZE_WIDTH, 24, width of block size and remaining-word counter

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous active-low reset
i_rd_ready  in  1  FIFO has a filled block available
o_rd_activate  out  1  block claimed; held for the whole block
i_rd_size  in  SIZE_WIDTH  word count of the offered block, valid while i_rd_ready=1
o_rd_stb  out  1  pop one word
i_rd_data  in  DATA_WIDTH  popped word, valid the cycle after o_rd_stb
o_data  out  DATA_WIDTH  stream data
o_valid  out  1  stream word valid
i_ready  in  1  stream sink accepts
o_last  out  1  o_data is the final word of its block
o_busy  out  1  state != IDLE or buffer non-empty
o_block_count  out  32  completed blocks since reset, wraps at 2^32

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; buffer empty; in-flight flag cleared; counters 0.
- Transfer: a word moves when o_valid & i_ready. Once o_valid rises, o_data, o_last and o_valid stay stable until accepted.
- Buffer: 2-entry FIFO of {data,last}. o_valid = not empty.
- in_flight is set the cycle o_rd_stb=1 and clears the next cycle, when i_rd_data is written into the buffer.
- Strobe rule:
  - o_rd_stb=1 iff state READ and remaining>0 and (occupancy + in_flight - pop_this_cycle) < 2.
  - This sustains 1 word/cycle while i_ready=1.
- IDLE:
  - o_rd_activate=0.
  - If i_rd_ready=1: latch remaining <= i_rd_size and orig_size <= i_rd_size, set o_rd_activate=1 next cycle, go READ.
- READ:
  - Each strobe decrements remaining.
  - The word from the strobe that takes remaining 1->0 is captured with last=1.
  - When remaining==0 and in_flight==0: go RELEASE.
  - Zero-size case: if the latched size is 0, READ passes straight to RELEASE. o_rd_activate is high exactly 1 cycle, no words and no last are emitted, and o_block_count still increments.
- RELEASE:
  - o_rd_activate <= 0, o_block_count += 1, go IDLE.
  - i_rd_ready is ignored in RELEASE; a new block can be claimed no earlier than 1 cycle after activate drops.
- The next block may be claimed while the buffer still holds words of the previous block. Ordering is preserved by the buffer.
- Width rules:
  - remaining is SIZE_WIDTH bits and never underflows, because strobes are gated by remaining>0.
  - Sizes up to 2^SIZE_WIDTH-1 are legal.
- Reset mid-block: all state is discarded immediately, including buffered words and o_rd_activate. Upstream FIFO recovery is the upstream's responsibility, since both share rst.
- i_ready going low mid-block: at most 2 words are outstanding; strobes stop until space frees.
- Simultaneous push and pop with the buffer full: occupancy is unchanged and is legal only because the strobe rule guarantees space.

Optional Feature:
Macro PPFIFO_STREAM_READER_STATS_EN.
- Defined: adds ports o_word_count (32, total words transferred on the stream) and o_stall_count (32, cycles with o_valid=1 & i_ready=0). Both reset to 0 and wrap.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Block size 4 with words 0xA0..0xA3, i_ready=1 -> 4 stream words in order, o_last=1 only on 0xA3, 4 o_rd_stb pulses on consecutive cycles, o_block_count=1, o_rd_activate low afterwards.
- Block size 8 with i_ready=0 for 10 cycles, then 1 -> exactly 2 strobes during the stall, all 8 words delivered once in order, o_last on the 8th.
- Size 0 block -> o_rd_activate high 1 cycle, no o_rd_stb, no o_valid, o_block_count=1.
- Two back-to-back blocks (size 3, then size 2) with i_ready toggling every cycle -> 5 words in order, o_last on words 3 and 5, o_block_count=2.
- Assert rst low while 2 words are buffered mid-block -> outputs 0 asynchronously. After release, a fresh size-2 block is delivered correctly with o_block_count=1.
- With PPFIFO_STREAM_READER_STATS_EN, a size-8 block with a 10-cycle stall -> o_word_count=8, o_stall_count=10.

Source files
------------

// File: rtl/ppfifo_stream_reader.sv
// Ping-pong FIFO read-side drainer: claims a block, pops its words and re-emits them as a valid/ready stream with o_last.
// Optional PPFIFO_STREAM_READER_STATS_EN adds o_word_count / o_stall_count.
module ppfifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_ready,
    output logic                  o_rd_activate,
    input  logic [SIZE_WIDTH-1:0] i_rd_size,
    output logic                  o_rd_stb,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy,
    output logic [31:0]           o_block_count
`ifdef PPFIFO_STREAM_READER_STATS_EN
    ,
    output logic [31:0]           o_word_count,
    output logic [31:0]           o_stall_count
`endif
);

    typedef enum logic [1:0] {IDLE, READ, RELEASE} state_t;

    state_t                state_reg;
    logic [SIZE_WIDTH-1:0] remaining_reg;
    logic                  in_flight_reg;
    logic                  flight_last_reg;

    logic [DATA_WIDTH-1:0] buf_data_reg [2];
    logic                  buf_last_reg [2];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;

    logic                  push;
    logic                  pop;
    logic [1:0]            room_used;

    assign push      = in_flight_reg;
    assign o_valid   = (count_reg != 2'd0);
    assign pop       = o_valid & i_ready;
    assign o_data    = buf_data_reg[rd_ptr_reg];
    assign o_last    = buf_last_reg[rd_ptr_reg];
    assign o_busy    = (state_reg != IDLE) || o_valid;

    // Words already committed to the buffer after this cycle; a new strobe only if its word will fit.
    assign room_used = count_reg + {1'b0, in_flight_reg} - {1'b0, pop};
    assign o_rd_stb  = (state_reg == READ) && (remaining_reg != '0) && (room_used < 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            remaining_reg   <= '0;
            in_flight_reg   <= 1'b0;
            flight_last_reg <= 1'b0;
            o_rd_activate   <= 1'b0;
            o_block_count   <= 32'd0;
        end else begin
            in_flight_reg <= o_rd_stb;
            if (o_rd_stb) begin
                flight_last_reg <= (remaining_reg == SIZE_WIDTH'(1));
            end
            case (state_reg)
                IDLE: begin
                    if (i_rd_ready) begin
                        remaining_reg <= i_rd_size;
                        o_rd_activate <= 1'b1;
                        state_reg     <= READ;
                    end
                end
                READ: begin
                    if (o_rd_stb) begin
                        remaining_reg <= remaining_reg - SIZE_WIDTH'(1);
                    end
                    // Hold activate until the last popped word has actually arrived.
                    if ((remaining_reg == '0) && !in_flight_reg) begin
                        o_rd_activate <= 1'b0;
                        state_reg     <= RELEASE;
                    end
                end
                RELEASE: begin
                    o_rd_activate <= 1'b0;
                    o_block_count <= o_block_count + 32'd1;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_reg[0] <= '0;
            buf_data_reg[1] <= '0;
            buf_last_reg[0] <= 1'b0;
            buf_last_reg[1] <= 1'b0;
            wr_ptr_reg      <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
        end else begin
            if (push) begin
                buf_data_reg[wr_ptr_reg] <= i_rd_data;
                buf_last_reg[wr_ptr_reg] <= flight_last_reg;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef PPFIFO_STREAM_READER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_word_count  <= 32'd0;
            o_stall_count <= 32'd0;
        end else begin
            if (pop) begin
                o_word_count <= o_word_count + 32'd1;
            end
            if (o_valid && !i_ready) begin
                o_stall_count <= o_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ppfifo_stream_reader.sv
// Bench for ppfifo_stream_reader: upstream block FIFO model, expected-word scoreboard, table rows and corner sequences.
`timescale 1ns/1ps
module tb_ppfifo_stream_reader;
    localparam int DW = 32;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_rd_ready = 1'b0;
    logic          o_rd_activate;
    logic [SW-1:0] i_rd_size = '0;
    logic          o_rd_stb;
    logic [DW-1:0] i_rd_data = '0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic          o_last;
    logic          o_busy;
    logic [31:0]   o_block_count;
`ifdef PPFIFO_STREAM_READER_STATS_EN
    logic [31:0]   o_word_count;
    logic [31:0]   o_stall_count;
`endif

    always #5 clk = ~clk;

    ppfifo_stream_reader #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rd_ready    (i_rd_ready),
        .o_rd_activate (o_rd_activate),
        .i_rd_size     (i_rd_size),
        .o_rd_stb      (o_rd_stb),
        .i_rd_data     (i_rd_data),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_block_count (o_block_count)
`ifdef PPFIFO_STREAM_READER_STATS_EN
        ,
        .o_word_count  (o_word_count),
        .o_stall_count (o_stall_count)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        int unsigned size;
        int          mode;
        logic [31:0] base;
        int unsigned exp_stbs;
        int unsigned exp_lasts;
        logic [31:0] exp_blocks;
        bit          consec;
        int unsigned exp_act;
    } vec_t;

    word_t       exp_q[$];
    int unsigned blk_sizes[$];
    logic [31:0] blk_words[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    bit          claimed = 0;
    bit          stb_pending = 0;
    bit          hold_prev = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int unsigned cur_left = 0;
    int unsigned stb_total = 0, acc_total = 0, stall_model = 0, blocks_enq = 0, lasts_seen = 0;
    int unsigned blk_stbs = 0, blk_act = 0, last_blk_stbs = 0, last_blk_act = 0, last_blk_span = 0;
    int          blk_first_stb = 0, blk_last_stb = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enqueue a block upstream and append its words to the expected stream.
    task automatic add_block(input int unsigned size, input logic [31:0] base, input bit rnd);
        blk_sizes.push_back(size);
        blocks_enq++;
        for (int unsigned k = 0; k < size; k++) begin
            word_t w;
            w.data = rnd ? 32'($urandom) : base + 32'(k);
            w.last = (k == size - 1);
            blk_words.push_back(w.data);
            exp_q.push_back(w);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (stb_pending && blk_words.size() > 0) begin
            i_rd_data = blk_words.pop_front();
        end else begin
            i_rd_data = 32'($urandom);
        end
        stb_pending = 0;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'b0;
            2:       i_ready = ~i_ready;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
        if (!claimed && o_rd_activate) begin
            claimed = 1;
            chk("claim_pending", blk_sizes.size() > 0, 1);
            if (blk_sizes.size() > 0) cur_left = blk_sizes.pop_front();
            blk_stbs = 0;
            blk_act = 0;
        end else if (claimed && !o_rd_activate) begin
            claimed = 0;
            chk("block_words_strobed", cur_left, 0);
            last_blk_stbs = blk_stbs;
            last_blk_act  = blk_act;
            last_blk_span = (blk_stbs != 0) ? int'(blk_last_stb - blk_first_stb + 1) : 0;
        end
        if (claimed) blk_act++;
        i_rd_ready = !claimed && !o_rd_activate && (blk_sizes.size() > 0);
        i_rd_size  = (blk_sizes.size() > 0) ? SW'(blk_sizes[0]) : '0;
        #1;
        if (hold_prev) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_data", o_data, prev_data);
            chk("hold_last", o_last, prev_last);
        end
        if (o_rd_stb) begin
            chk("stb_in_block", claimed && (cur_left > 0), 1);
            if (cur_left > 0) cur_left--;
            if (blk_stbs == 0) blk_first_stb = cyc;
            blk_last_stb = cyc;
            blk_stbs++;
            stb_total++;
            stb_pending = 1;
        end
        if (o_valid && i_ready) begin
            acc_total++;
            if (exp_q.size() == 0) begin
                chk("extra_word", o_valid, 0);
            end else begin
                word_t w = exp_q.pop_front();
                chk("word_data", o_data, w.data);
                chk("word_last", o_last, w.last);
                if (o_last) lasts_seen++;
            end
            $display("word %0d data=%08h last=%0b blocks=%0d", acc_total, o_data, o_last, o_block_count);
        end
        if (o_valid && !i_ready) stall_model++;
        chk("outstanding_le_2", (stb_total - acc_total) <= 2, 1);
        hold_prev = o_valid && !i_ready;
        prev_data = o_data;
        prev_last = o_last;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(blk_sizes.size() == 0 && !claimed && exp_q.size() == 0 && !o_busy && !o_rd_activate)
               && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!o_valid && n < budget) begin
            step();
            n++;
        end
        chk("valid_in_budget", o_valid, 1);
    endtask

    initial begin
        vec_t        vecs[5];
        int unsigned l0, s0;
        logic [31:0] b0;
`ifdef PPFIFO_STREAM_READER_STATS_EN
        logic [31:0] wc0, sc0;
`endif
        vecs[0] = '{size: 4, mode: 0, base: 32'hA0, exp_stbs: 4, exp_lasts: 1, exp_blocks: 1, consec: 1, exp_act: 0};
        vecs[1] = '{size: 0, mode: 0, base: 32'h00, exp_stbs: 0, exp_lasts: 0, exp_blocks: 2, consec: 0, exp_act: 1};
        vecs[2] = '{size: 1, mode: 3, base: 32'hB0, exp_stbs: 1, exp_lasts: 1, exp_blocks: 3, consec: 0, exp_act: 0};
        vecs[3] = '{size: 5, mode: 2, base: 32'hC0, exp_stbs: 5, exp_lasts: 1, exp_blocks: 4, consec: 0, exp_act: 0};
        vecs[4] = '{size: 7, mode: 0, base: 32'hD0, exp_stbs: 7, exp_lasts: 1, exp_blocks: 5, consec: 1, exp_act: 0};

        #12;
        chk("reset_valid", o_valid, 0);
        chk("reset_activate", o_rd_activate, 0);
        chk("reset_stb", o_rd_stb, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_blocks", o_block_count, 0);
        chk("reset_data", o_data, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[r]) begin
            ready_mode = vecs[r].mode;
            l0 = lasts_seen;
            add_block(vecs[r].size, vecs[r].base, 0);
            drain(300);
            chk($sformatf("row%0d_stbs", r), last_blk_stbs, vecs[r].exp_stbs);
            chk($sformatf("row%0d_lasts", r), lasts_seen - l0, vecs[r].exp_lasts);
            chk($sformatf("row%0d_blocks", r), o_block_count, vecs[r].exp_blocks);
            chk($sformatf("row%0d_act_low", r), o_rd_activate, 0);
            if (vecs[r].consec) chk($sformatf("row%0d_stb_span", r), last_blk_span, vecs[r].exp_stbs);
            if (vecs[r].exp_act != 0) chk($sformatf("row%0d_act_cycles", r), last_blk_act, vecs[r].exp_act);
        end

        // Size 8 with a 10-cycle stall once data is presented.
`ifdef PPFIFO_STREAM_READER_STATS_EN
        wc0 = o_word_count;
        sc0 = o_stall_count;
`endif
        ready_mode = 1;
        s0 = stb_total;
        l0 = lasts_seen;
        add_block(8, 32'hE0, 0);
        wait_valid(30);
        repeat (9) step();
        chk("stall_stbs", stb_total - s0, 2);
        ready_mode = 0;
        drain(300);
        chk("stall_lasts", lasts_seen - l0, 1);
        chk("stall_blocks", o_block_count, 6);
`ifdef PPFIFO_STREAM_READER_STATS_EN
        chk("stats_word_delta", o_word_count - wc0, 8);
        chk("stats_stall_delta", o_stall_count - sc0, 10);
`endif

        // Back-to-back blocks with a toggling sink.
        ready_mode = 2;
        l0 = lasts_seen;
        b0 = o_block_count;
        add_block(3, 32'h30, 0);
        add_block(2, 32'h40, 0);
        drain(300);
        chk("b2b_lasts", lasts_seen - l0, 2);
        chk("b2b_blocks", o_block_count - b0, 2);

        // Asynchronous reset with two words buffered.
        ready_mode = 1;
        add_block(6, 32'h50, 0);
        wait_valid(30);
        step();
        chk("pre_reset_outstanding", stb_total - acc_total, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_activate", o_rd_activate, 0);
        chk("arst_stb", o_rd_stb, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_blocks", o_block_count, 0);
        chk("arst_data", o_data, 0);
        chk("arst_last", o_last, 0);
        exp_q.delete();
        blk_sizes.delete();
        blk_words.delete();
        claimed = 0; stb_pending = 0; hold_prev = 0; cur_left = 0;
        stb_total = 0; acc_total = 0; stall_model = 0; blocks_enq = 0;
        i_rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ready_mode = 0;
        l0 = lasts_seen;
        add_block(2, 32'h60, 0);
        drain(100);
        chk("post_reset_blocks", o_block_count, 1);
        chk("post_reset_lasts", lasts_seen - l0, 1);

        // Randomised blocks and sink behaviour against the scoreboard.
        ready_mode = 3;
        for (int i = 0; i < 25; i++) add_block($urandom_range(0, 9), 32'h0, 1);
        drain(3000);
        chk("rand_blocks", o_block_count, blocks_enq);
        chk("rand_busy", o_busy, 0);
`ifdef PPFIFO_STREAM_READER_STATS_EN
        chk("rand_word_count", o_word_count, acc_total);
        chk("rand_stall_count", o_stall_count, stall_model);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
